// File: rtl/mod_n_div_counter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Package : div_pkg
// | Shared direction constants and next-state select for mod_n_div_counter.
// | Rev     : 1.0
// +-----------------------------------------------------------------------------
package div_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [2:0] {
    SEL_RST  = 3'd0,
    SEL_CLR  = 3'd1,
    SEL_LD   = 3'd2,
    SEL_CNT  = 3'd3,
    SEL_HOLD = 3'd4
  } sel_e;

endpackage
`default_nettype wire

// File: rtl/mod_n_div_counter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Interface : mod_n_div_counter_if
// | Control/status bundle of one divider stage.
// | Rev       : 1.0
// +-----------------------------------------------------------------------------
interface mod_n_div_counter_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic             up;
  logic             clr;
  logic             mod_ld;
  logic [WIDTH-1:0] mod_in;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             tick;

  modport master (
    output en, up, clr, mod_ld, mod_in,
    input  cnt, tc, tick
  );

  modport slave (
    input  en, up, clr, mod_ld, mod_in,
    output cnt, tc, tick
  );

endinterface
`default_nettype wire

// File: rtl/mod_n_div_counter_inc_dec.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module : inc_dec
// | Combinational +/-1 step with wrap inside 0..last.
// | Rev    : 1.0
// +-----------------------------------------------------------------------------
module inc_dec
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH-1:0] last_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] nxt_o
);

  always_comb begin
    nxt_o = cnt_i;
    if (up_i == DIR_UP) begin
      nxt_o = (cnt_i == last_i) ? '0 : cnt_i + WIDTH'(1);
    end else begin
      nxt_o = (cnt_i == '0) ? last_i : cnt_i - WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mod_n_div_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module : mod_n_div_counter
// | Up/down modulo-N counter with runtime modulus and cascadable terminal tick.
// | Rev    : 1.0
// +-----------------------------------------------------------------------------
module mod_n_div_counter
  import div_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_MOD = 3
) (
  input  logic                clk,
  input  logic                rst,
  mod_n_div_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_DEFAULT_MOD = WIDTH'(DEFAULT_MOD);

  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $fatal(1, "mod_n_div_counter: WIDTH must be 2..16");
    end
    if (DEFAULT_MOD < 0 || DEFAULT_MOD >= (1 << WIDTH)) begin : g_bad_default
      $fatal(1, "mod_n_div_counter: DEFAULT_MOD must be < 2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] w_last;
  logic [WIDTH-1:0] w_nxt;
  logic             w_tc;
  sel_e             w_sel;

  // A zero modulus wraps to all-ones here, giving the full 2**WIDTH range.
  assign w_last = mod_q - WIDTH'(1);

  inc_dec #(
    .WIDTH (WIDTH)
  ) u_inc_dec (
    .cnt_i  (cnt_q),
    .last_i (w_last),
    .up_i   (bus.up),
    .nxt_o  (w_nxt)
  );

  assign w_tc = (bus.up == DIR_DN) ? (cnt_q == '0) : (cnt_q == w_last);

  always_comb begin
    w_sel = SEL_HOLD;
    if (rst)             w_sel = SEL_RST;
    else if (bus.clr)    w_sel = SEL_CLR;
    else if (bus.mod_ld) w_sel = SEL_LD;
    else if (bus.en)     w_sel = SEL_CNT;
  end

  always_comb begin
    cnt_d = cnt_q;
    mod_d = mod_q;
    case (w_sel)
      SEL_RST: begin
        cnt_d = '0;
        mod_d = c_DEFAULT_MOD;
      end
      SEL_CLR:  cnt_d = '0;
      SEL_LD: begin
        cnt_d = '0;
        mod_d = bus.mod_in;
      end
      SEL_CNT:  cnt_d = w_nxt;
      SEL_HOLD: cnt_d = cnt_q;
      default:  cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      mod_q <= c_DEFAULT_MOD;
    end else begin
      cnt_q <= cnt_d;
      mod_q <= mod_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.tc   = w_tc;
  assign bus.tick = bus.en & w_tc & ~bus.clr & ~bus.mod_ld;

endmodule
`default_nettype wire

// File: tb/tb_mod_n_div_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module : tb_mod_n_div_counter
// | Two cascaded divider stages checked against an arithmetic modulo model.
// | Rev    : 1.0
// +-----------------------------------------------------------------------------
module tb_mod_n_div_counter;

  localparam int W  = 4;
  localparam int DM = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_n_div_counter_if #(.WIDTH(W)) a_if ();
  mod_n_div_counter_if #(.WIDTH(W)) b_if ();

  // Stage B is enabled by stage A's carry.
  assign b_if.en = a_if.tick;

  mod_n_div_counter #(.WIDTH(W), .DEFAULT_MOD(DM)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  mod_n_div_counter #(.WIDTH(W), .DEFAULT_MOD(DM)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  typedef struct {
    int   cyc;
    int   a_cnt;
    bit   a_tc;
    bit   a_tick;
    int   b_cnt;
    bit   b_tc;
    bit   b_tick;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  int ma_cnt, ma_mod, mb_cnt, mb_mod;

  function automatic int modv(input int m);
    return (m == 0) ? (1 << W) : m;
  endfunction

  task automatic cmp(input string name, input int c, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  // One clock of stimulus: drive, predict visible outputs, advance the model.
  task automatic step(input bit r, input bit e, input bit u, input bit c,
                      input bit l, input int mi, input bit bl, input bit chk);
    int   am, bm;
    exp_t x;
    rst         = r;
    a_if.en     = e;
    a_if.up     = u;
    a_if.clr    = c;
    a_if.mod_ld = l;
    a_if.mod_in = W'(mi);
    b_if.up     = 1'b1;
    b_if.clr    = 1'b0;
    b_if.mod_ld = bl;
    b_if.mod_in = W'(6);

    am       = modv(ma_mod);
    bm       = modv(mb_mod);
    x.cyc    = cyc;
    x.a_cnt  = ma_cnt;
    x.a_tc   = u ? (ma_cnt == am - 1) : (ma_cnt == 0);
    x.a_tick = e && x.a_tc && !c && !l;
    x.b_cnt  = mb_cnt;
    x.b_tc   = (mb_cnt == bm - 1);
    x.b_tick = x.a_tick && x.b_tc && !bl;
    if (chk) q.push_back(x);

    if (r) begin
      ma_cnt = 0; ma_mod = DM;
    end else if (c) begin
      ma_cnt = 0;
    end else if (l) begin
      ma_cnt = 0; ma_mod = mi % (1 << W);
    end else if (e) begin
      ma_cnt = u ? (ma_cnt + 1) % am : (ma_cnt + am - 1) % am;
    end

    if (r) begin
      mb_cnt = 0; mb_mod = DM;
    end else if (bl) begin
      mb_cnt = 0; mb_mod = 6;
    end else if (x.a_tick) begin
      mb_cnt = (mb_cnt + 1) % bm;
    end

    cyc++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      cmp("a_cnt",  x.cyc, int'(a_if.cnt),  x.a_cnt);
      cmp("a_tc",   x.cyc, int'(a_if.tc),   int'(x.a_tc));
      cmp("a_tick", x.cyc, int'(a_if.tick), int'(x.a_tick));
      cmp("b_cnt",  x.cyc, int'(b_if.cnt),  x.b_cnt);
      cmp("b_tc",   x.cyc, int'(b_if.tc),   int'(x.b_tc));
      cmp("b_tick", x.cyc, int'(b_if.tick), int'(x.b_tick));
    end
  end

  initial begin
    ma_cnt = 0; ma_mod = DM; mb_cnt = 0; mb_mod = DM;
    step(1, 0, 1, 0, 0, 0, 0, 0);

    // Basic mod-3 up count; stage B gets modulus 6 alongside.
    step(0, 1, 1, 0, 0, 0, 1, 1);
    repeat (7) step(0, 1, 1, 0, 0, 0, 0, 1);

    // Load 10 while sitting at the terminal value.
    step(0, 1, 1, 0, 1, 10, 0, 1);
    repeat (12) step(0, 1, 1, 0, 0, 0, 0, 1);

    // Full-range modulus, then divide-by-1.
    step(0, 1, 1, 0, 1, 0, 0, 1);
    repeat (17) step(0, 1, 1, 0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 1, 1, 0, 1);
    repeat (4) step(0, 1, 1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0, 1);

    // Down count mod 3 and a direction flip at cnt=1.
    step(0, 1, 0, 0, 1, 3, 0, 1);
    repeat (5) step(0, 1, 0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 1, 1, 0, 0, 0, 0, 1);

    // Hold, clear at terminal, reset over a simultaneous load.
    step(0, 1, 1, 0, 1, 10, 0, 1);
    repeat (5) step(0, 1, 1, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 1, 0, 0, 0, 0, 1);
    repeat (4) step(0, 1, 1, 0, 0, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0, 1);
    step(1, 1, 1, 0, 1, 7, 0, 1);
    repeat (4) step(0, 1, 1, 0, 0, 0, 0, 1);

    // Cascade: A mod 10 feeding B mod 6 for 60 cycles.
    step(0, 0, 1, 0, 1, 10, 1, 1);
    repeat (61) step(0, 1, 1, 0, 0, 0, 0, 1);

    // Randomised mix of all controls.
    for (int i = 0; i < 500; i++) begin
      step(($urandom % 64) == 0,
           ($urandom % 4) != 0,
           $urandom % 2,
           ($urandom % 16) == 0,
           ($urandom % 16) == 0,
           int'($urandom % 16),
           ($urandom % 32) == 0,
           1);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
